// File: rtl/dac_pkg.sv
// dac_pkg: shared definitions for the DAC PWM / sigma-delta output stage.
//   DAC_WIDTH       code width; one PWM period is 2^DAC_WIDTH cycles
//   DAC_PERIOD_LAST last count value of a period
//   dac_state_t     stage FSM states
package dac_pkg;

   localparam int DAC_WIDTH = 8;
   localparam logic [DAC_WIDTH-1:0] DAC_PERIOD_LAST = {DAC_WIDTH{1'b1}};

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } dac_state_t;

endpackage

// File: rtl/dac_pwm_stage_rise_det.sv
// rise_det: registers a level-type valid flag and flags its 0->1 transition.
// Shared by loader consumers that react to the loader's stop flag.
//   clk      in   system clock
//   rst_n    in   async active-low reset
//   i_level  in   level input (loader stop flag)
//   o_rise   out  high in the cycle i_level is high and was low last cycle
module rise_det (
   input  logic clk,
   input  logic rst_n,
   input  logic i_level,
   output logic o_rise
);

   logic r_level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_level_q <= 1'b0;
      else        r_level_q <= i_level;
   end

   assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/dac_pwm_stage.sv
// dac_pwm_stage: turns a double-buffered DAC code into a 1-bit drive stream
// for an external RC filter. New codes are staged in a shadow register and
// applied only at a period boundary so the waveform never glitches.
// Optional first-order sigma-delta output: define DAC_SIGMA_DELTA_EN.
//   clk          in   system clock
//   rst_n        in   async active-low reset
//   ena          in   run enable; low holds count/accumulator, drives 0
//   word_in      in   code from the loader
//   word_valid   in   loader stop flag (level); rising edge = new code
//   soft_clr     in   synchronous return to IDLE, drops any staged code
//   pwm_out      out  PWM drive, high while count < applied code
//   sd_out       out  sigma-delta drive (0 unless DAC_SIGMA_DELTA_EN)
//   period_done  out  pulse on the last count of a period
//   busy         out  high while running
//
// state | meaning
// IDLE  | no code applied yet, outputs 0, waiting for a new code
// RUN   | counting periods and driving the applied code
module dac_pwm_stage
   import dac_pkg::*;
#(
   parameter int WIDTH = DAC_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] word_in,
   input  logic             word_valid,
   input  logic             soft_clr,
   output logic             pwm_out,
   output logic             sd_out,
   output logic             period_done,
   output logic             busy
);

   localparam logic [WIDTH-1:0] PERIOD_LAST = {WIDTH{1'b1}};

   dac_state_t       r_state;
   dac_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_active;
   logic [WIDTH-1:0] r_pending;
   logic             r_pend_flag;
   logic             w_rise;
   logic             w_run;
   logic             w_step;
   logic             w_boundary;

   rise_det u_rise_det (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_level (word_valid),
      .o_rise  (w_rise)
   );

   assign w_run      = (r_state == RUN);
   assign w_step     = w_run & ena;
   assign w_boundary = w_step & (r_cnt == PERIOD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_rise) w_state_nxt = RUN;
         RUN:     w_state_nxt = RUN;
         default: w_state_nxt = IDLE;
      endcase
      if (soft_clr) w_state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_active    <= '0;
         r_pending   <= '0;
         r_pend_flag <= 1'b0;
      end else if (soft_clr) begin
         r_cnt       <= '0;
         r_active    <= '0;
         r_pending   <= '0;
         r_pend_flag <= 1'b0;
      end else if (!w_run) begin
         r_cnt <= '0;
         if (w_rise) begin
            r_active    <= word_in;
            r_pending   <= word_in;
            r_pend_flag <= 1'b0;
         end
      end else begin
         if (w_step) r_cnt <= r_cnt + 1'b1;
         // A code arriving on the boundary itself bypasses the shadow register.
         if (w_boundary && w_rise) begin
            r_active    <= word_in;
            r_pending   <= word_in;
            r_pend_flag <= 1'b0;
         end else if (w_boundary && r_pend_flag) begin
            r_active    <= r_pending;
            r_pend_flag <= 1'b0;
         end else if (w_rise) begin
            r_pending   <= word_in;
            r_pend_flag <= 1'b1;
         end
      end
   end

   // Run-enable gates the drives directly so a pause silences the filter
   // input in the same cycle rather than one cycle late.
   assign busy        = w_run;
   assign pwm_out     = w_step & (r_cnt < r_active);
   assign period_done = w_boundary;

`ifdef DAC_SIGMA_DELTA_EN
   logic [WIDTH-1:0] r_acc;
   logic             r_sd;
   logic [WIDTH:0]   w_acc_sum;

   assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_active};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_sd  <= 1'b0;
      end else if (soft_clr || !w_run) begin
         r_acc <= '0;
         r_sd  <= 1'b0;
      end else if (w_step) begin
         r_acc <= w_acc_sum[WIDTH-1:0];
         r_sd  <= w_acc_sum[WIDTH];
      end
   end

   assign sd_out = w_step & r_sd;
`else
   assign sd_out = 1'b0;
`endif

endmodule

// File: tb/tb_dac_pwm_stage.sv
// tb_dac_pwm_stage: directed stimulus with a cycle-level integer model of the
// DAC stage (phase, applied duty, staged code) checked on every falling edge,
// plus hand-computed per-period duty counts that pin the model.
module tb_dac_pwm_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] word_in;
   logic       word_valid;
   logic       soft_clr;
   logic       pwm_out;
   logic       sd_out;
   logic       period_done;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dac_pwm_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .word_in     (word_in),
      .word_valid  (word_valid),
      .soft_clr    (soft_clr),
      .pwm_out     (pwm_out),
      .sd_out      (sd_out),
      .period_done (period_done),
      .busy        (busy)
   );

   // pend = -1 means no staged code
   typedef struct {
      int busy;
      int phase;
      int duty;
      int pend;
      int acc;
      int sdq;
      int prev;
   } mstate_t;

   function automatic mstate_t model_reset();
      mstate_t r;
      r.busy = 0; r.phase = 0; r.duty = 0; r.pend = -1;
      r.acc = 0; r.sdq = 0; r.prev = 0;
      return r;
   endfunction

   function automatic mstate_t model_next(mstate_t m, logic wv, logic [7:0] wi,
                                          logic en, logic clr);
      mstate_t n;
      bit      rise;
      n = m;
      rise = wv && (m.prev == 0);
      n.prev = int'(wv);
      if (clr) begin
         n = model_reset();
         n.prev = int'(wv);
      end else if (m.busy == 0) begin
         n.phase = 0; n.acc = 0; n.sdq = 0;
         if (rise) begin
            n.busy = 1; n.duty = int'(wi); n.pend = -1;
         end
      end else begin
         if (en) begin
            n.sdq   = ((m.acc + m.duty) >= 256) ? 1 : 0;
            n.acc   = (m.acc + m.duty) % 256;
            n.phase = (m.phase + 1) % 256;
         end
         if (en && m.phase == 255) begin
            if (rise) begin
               n.duty = int'(wi); n.pend = -1;
            end else if (m.pend >= 0) begin
               n.duty = m.pend; n.pend = -1;
            end
         end else if (rise) begin
            n.pend = int'(wi);
         end
      end
      return n;
   endfunction

   mstate_t m = model_reset();

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_next(m, word_valid, word_in, ena, soft_clr);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d, t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      int e_pwm, e_pd, e_sd;
      e_pwm = (m.busy != 0 && ena && m.phase < m.duty) ? 1 : 0;
      e_pd  = (m.busy != 0 && ena && m.phase == 255) ? 1 : 0;
`ifdef DAC_SIGMA_DELTA_EN
      e_sd  = (m.busy != 0 && ena && m.sdq != 0) ? 1 : 0;
`else
      e_sd  = 0;
`endif
      chk("model_busy", int'(busy), m.busy);
      chk("model_pwm", int'(pwm_out), e_pwm);
      chk("model_period_done", int'(period_done), e_pd);
      chk("model_sd", int'(sd_out), e_sd);
   end

   task automatic window(input int n, output int p, output int d, output int s);
      p = 0; d = 0; s = 0;
      repeat (n) begin
         @(negedge clk);
         p += int'(pwm_out);
         d += int'(period_done);
         s += int'(sd_out);
         @(posedge clk);
         #1;
      end
   endtask

   // Called at count 0: runs to the last count, then raises a new code there.
   task automatic load_at_boundary(input logic [7:0] code);
      int p, d, s;
      word_valid = 1'b0;
      window(255, p, d, s);
      word_in    = code;
      word_valid = 1'b1;
      window(1, p, d, s);
   endtask

   initial begin
      int p, d, s, p1, p2, p3, d1, d2, s1, s2;
      rst_n = 1'b0; ena = 1'b1; word_in = '0; word_valid = 1'b0; soft_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_pwm", int'(pwm_out), 0);
      chk("reset_period_done", int'(period_done), 0);
      chk("reset_sd", int'(sd_out), 0);
      window(5, p, d, s);
      chk("idle_pwm_count", p, 0);

      // first code 64
      word_in = 8'd64; word_valid = 1'b1;
      @(posedge clk); #1;
      chk("busy_after_rise", int'(busy), 1);
      window(256, p, d, s);
      chk("duty64_first", p, 64);
      chk("pd_first", d, 1);
      window(256, p, d, s);
      chk("duty64_second", p, 64);
      chk("pd_second", d, 1);

      // staged updates mid-period, last one wins
      word_valid = 1'b0;
      window(10, p, d, s);
      word_in = 8'd200; word_valid = 1'b1;
      window(5, p1, d, s);
      word_valid = 1'b0;
      window(5, p2, d, s);
      word_in = 8'd5; word_valid = 1'b1;
      window(236, p3, d, s);
      chk("hold_until_boundary", p1 + p2 + p3, 54);
      chk("pd_hold", d, 1);
      window(256, p, d, s);
      chk("last_word_wins", p, 5);

      // bypass on boundary
      load_at_boundary(8'd128);
      window(256, p, d, s);
      chk("bypass_128", p, 128);
      chk("pd_bypass", d, 1);
      window(256, p, d, s);
      chk("bypass_no_stale", p, 128);

      // extreme codes
      load_at_boundary(8'd0);
      window(256, p, d, s);
      chk("code0", p, 0);
      load_at_boundary(8'd255);
      window(256, p, d, s);
      chk("code255", p, 255);
      chk("pd_code255", d, 1);
      load_at_boundary(8'd64);
      window(256, p, d, s);
      chk("code64_again", p, 64);
`ifdef DAC_SIGMA_DELTA_EN
      chk("sd_density64", s, 64);
`endif

      // freeze mid-period, rise while frozen
      window(30, p1, d, s);
      ena = 1'b0; word_valid = 1'b0;
      window(5, p2, d1, s1);
      word_in = 8'd200; word_valid = 1'b1;
      window(15, p3, d2, s2);
      chk("freeze_pwm", p2 + p3, 0);
      chk("freeze_pd", d1 + d2, 0);
      chk("freeze_sd", s1 + s2, 0);
      ena = 1'b1;
      window(226, p, d, s);
      chk("resume_duty", p1 + p, 64);
      chk("resume_pd", d, 1);
      window(256, p, d, s);
      chk("freeze_pending_applied", p, 200);

      // soft clear together with a rise
      word_valid = 1'b0;
      window(1, p, d, s);
      word_in = 8'd77; word_valid = 1'b1; soft_clr = 1'b1;
      @(posedge clk); #1;
      soft_clr = 1'b0;
      chk("softclr_busy", int'(busy), 0);
      window(10, p, d, s);
      chk("softclr_pwm_count", p + d + s, 0);
      chk("softclr_still_idle", int'(busy), 0);

      // restart, then async reset mid-period
      word_valid = 1'b0;
      window(1, p, d, s);
      word_in = 8'd64; word_valid = 1'b1;
      window(1, p, d, s);
      chk("restart_busy", int'(busy), 1);
      window(40, p, d, s);
      chk("pwm_before_reset", int'(pwm_out), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_busy", int'(busy), 0);
      chk("async_pwm", int'(pwm_out), 0);
      chk("async_pd", int'(period_done), 0);
      chk("async_sd", int'(sd_out), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      window(20, p, d, s);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
